// File: rtl/dma_csr_axil.sv
// AXI4-Lite control/status register file for the DMA engine.
// Holds control and descriptor fields; captures sticky done/error status and drives the irq.
module dma_csr_axil #(
  parameter int NUM_DESC   = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [31:0]                    s_wdata,
  input  logic [3:0]                     s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [7:0]                     s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [31:0]                    s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic                           go_o,
  output logic                           abort_o,
  output logic [7:0]                     max_burst_o,
  output logic [NUM_DESC*ADDR_WIDTH-1:0] desc_src_o,
  output logic [NUM_DESC*ADDR_WIDTH-1:0] desc_dst_o,
  output logic [NUM_DESC*32-1:0]         desc_bytes_o,
  output logic [NUM_DESC*3-1:0]          desc_cfg_o,
  input  logic                           dma_done_i,
  input  logic                           dma_active_i,
  input  logic                           err_valid_i,
  input  logic [ADDR_WIDTH-1:0]          err_addr_i,
  input  logic                           err_src_i,
  input  logic                           err_type_i,
  output logic                           irq_o
);

  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  localparam logic [5:0] DESC_END = 6'(8 + 4 * NUM_DESC);

  wstate_t w_state;
  rstate_t r_state;

  logic [5:0]  awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic                  abort_r, irq_en;
  logic [7:0]            max_burst;
  logic                  done_sticky, err_sticky, done_q;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic                  err_src, err_type;

  logic [ADDR_WIDTH-1:0] desc_src   [NUM_DESC];
  logic [ADDR_WIDTH-1:0] desc_dst   [NUM_DESC];
  logic [31:0]           desc_bytes [NUM_DESC];
  logic [2:0]            desc_cfg   [NUM_DESC];

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    return res;
  endfunction

  logic        aw_hs, w_hs, wr_commit, wr_err, wi_desc;
  logic [5:0]  wi;
  logic [3:0]  wsel;
  logic [31:0] cur_data;
  logic [3:0]  cur_strb;
  logic [31:0] ctrl_next;

  assign aw_hs    = s_awvalid & s_awready;
  assign w_hs     = s_wvalid & s_wready;
  assign wi       = (w_state == W_AW) ? awaddr_q : s_awaddr[7:2];
  assign cur_data = (w_state == W_W) ? wdata_q : s_wdata;
  assign cur_strb = (w_state == W_W) ? wstrb_q : s_wstrb;
  assign wsel     = 4'((wi - 6'd8) >> 2);
  assign wi_desc  = (wi >= 6'd8) && (wi < DESC_END);

  assign wr_commit = ((w_state == W_IDLE) & aw_hs & w_hs) |
                     ((w_state == W_AW) & w_hs) |
                     ((w_state == W_W) & aw_hs);

  // RO registers and unmapped words share the SLVERR path
  assign wr_err = !((wi == 6'd0) || (wi == 6'd1) || wi_desc) ||
                  (wi_desc && dma_active_i);

  assign ctrl_next = merge({21'b0, irq_en, max_burst, abort_r, 1'b0},
                           cur_data, cur_strb);

  logic unused_bits;
  assign unused_bits = ^{ctrl_next[31:11], ctrl_next[0],
                         s_awaddr[1:0], s_araddr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= 2'b00;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s_awready <= 1'b1;
          s_wready  <= 1'b1;
          if (wr_commit) begin
            w_state   <= W_RESP;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= wr_err ? 2'b10 : 2'b00;
          end else if (aw_hs) begin
            w_state   <= W_AW;
            s_awready <= 1'b0;
            awaddr_q  <= s_awaddr[7:2];
          end else if (w_hs) begin
            w_state  <= W_W;
            s_wready <= 1'b0;
            wdata_q  <= s_wdata;
            wstrb_q  <= s_wstrb;
          end
        end
        W_AW: if (wr_commit) begin
          w_state  <= W_RESP;
          s_wready <= 1'b0;
          s_bvalid <= 1'b1;
          s_bresp  <= wr_err ? 2'b10 : 2'b00;
        end
        W_W: if (wr_commit) begin
          w_state   <= W_RESP;
          s_awready <= 1'b0;
          s_bvalid  <= 1'b1;
          s_bresp   <= wr_err ? 2'b10 : 2'b00;
        end
        W_RESP: if (s_bready) begin
          w_state   <= W_IDLE;
          s_bvalid  <= 1'b0;
          s_awready <= 1'b1;
          s_wready  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_r     <= 1'b0;
      irq_en      <= 1'b0;
      max_burst   <= '0;
      go_o        <= 1'b0;
      done_sticky <= 1'b0;
      err_sticky  <= 1'b0;
      done_q      <= 1'b0;
      err_addr    <= '0;
      err_src     <= 1'b0;
      err_type    <= 1'b0;
      irq_o       <= 1'b0;
      for (int n = 0; n < NUM_DESC; n++) begin
        desc_src[n]   <= '0;
        desc_dst[n]   <= '0;
        desc_bytes[n] <= '0;
        desc_cfg[n]   <= '0;
      end
    end else begin
      go_o   <= 1'b0;
      done_q <= dma_done_i;
      irq_o  <= irq_en & (done_sticky | err_sticky);
      if (wr_commit && !wr_err) begin
        unique case (1'b1)
          wi == 6'd0: begin
            abort_r   <= ctrl_next[1];
            max_burst <= ctrl_next[9:2];
            irq_en    <= ctrl_next[10];
            go_o      <= cur_strb[0] & cur_data[0] & ~dma_active_i;
          end
          wi == 6'd1: if (cur_strb[0]) begin
            if (cur_data[0]) done_sticky <= 1'b0;
            if (cur_data[1]) err_sticky  <= 1'b0;
          end
          default: begin
            for (int n = 0; n < NUM_DESC; n++) begin
              if (wsel == 4'(n)) begin
                unique case (wi[1:0])
                  2'd0: desc_src[n] <= ADDR_WIDTH'(merge(32'(desc_src[n]),
                                                         cur_data, cur_strb));
                  2'd1: desc_dst[n] <= ADDR_WIDTH'(merge(32'(desc_dst[n]),
                                                         cur_data, cur_strb));
                  2'd2: desc_bytes[n] <= merge(desc_bytes[n],
                                               cur_data, cur_strb);
                  2'd3: if (cur_strb[0]) desc_cfg[n] <= cur_data[2:0];
                endcase
              end
            end
          end
        endcase
      end
      // hardware sets come last so they win over a same-cycle W1C
      if (dma_done_i && !done_q) done_sticky <= 1'b1;
      if (err_valid_i) begin
        err_sticky <= 1'b1;
        if (!err_sticky) begin
          err_addr <= err_addr_i;
          err_src  <= err_src_i;
          err_type <= err_type_i;
        end
      end
    end
  end

  logic [5:0]  ri;
  logic [3:0]  rsel;
  logic        rd_ok;
  logic [31:0] rd_val;

  assign ri   = s_araddr[7:2];
  assign rsel = 4'((ri - 6'd8) >> 2);

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    unique case (1'b1)
      ri == 6'd0: rd_val = {21'b0, irq_en, max_burst, abort_r, 1'b0};
      ri == 6'd1: rd_val = {29'b0, dma_active_i, err_sticky, done_sticky};
      ri == 6'd2: rd_val = 32'(err_addr);
      ri == 6'd3: rd_val = {30'b0, err_src, err_type};
      (ri >= 6'd8) && (ri < DESC_END): begin
        for (int n = 0; n < NUM_DESC; n++) begin
          if (rsel == 4'(n)) begin
            unique case (ri[1:0])
              2'd0: rd_val = 32'(desc_src[n]);
              2'd1: rd_val = 32'(desc_dst[n]);
              2'd2: rd_val = desc_bytes[n];
              2'd3: rd_val = {29'b0, desc_cfg[n]};
            endcase
          end
        end
      end
      default: rd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= 2'b00;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          s_arready <= 1'b1;
          if (s_arvalid && s_arready) begin
            r_state   <= R_DATA;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            s_rdata   <= rd_val;
            s_rresp   <= rd_ok ? 2'b00 : 2'b10;
          end
        end
        R_DATA: if (s_rready) begin
          r_state   <= R_IDLE;
          s_rvalid  <= 1'b0;
          s_arready <= 1'b1;
        end
      endcase
    end
  end

  assign abort_o     = abort_r;
  assign max_burst_o = max_burst;

  always_comb begin
    desc_src_o   = '0;
    desc_dst_o   = '0;
    desc_bytes_o = '0;
    desc_cfg_o   = '0;
    for (int n = 0; n < NUM_DESC; n++) begin
      desc_src_o[n*ADDR_WIDTH +: ADDR_WIDTH] = desc_src[n];
      desc_dst_o[n*ADDR_WIDTH +: ADDR_WIDTH] = desc_dst[n];
      desc_bytes_o[n*32 +: 32]               = desc_bytes[n];
      desc_cfg_o[n*3 +: 3]                   = desc_cfg[n];
    end
  end

endmodule

// File: tb/tb_dma_csr_axil.sv
// Directed bench for dma_csr_axil: AXI-Lite access, sticky status, irq, go/abort.
module tb_dma_csr_axil;

  localparam int LIM = 50;

  logic        clk, rst;
  logic [7:0]  s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [7:0]  s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic        go_o, abort_o;
  logic [7:0]  max_burst_o;
  logic [63:0] desc_src_o, desc_dst_o, desc_bytes_o;
  logic [5:0]  desc_cfg_o;
  logic        dma_done_i, dma_active_i, err_valid_i;
  logic [31:0] err_addr_i;
  logic        err_src_i, err_type_i, irq_o;

  int n_tests = 0;
  int n_fail  = 0;
  int go_cnt  = 0;

  dma_csr_axil #(.NUM_DESC(2), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .go_o(go_o), .abort_o(abort_o), .max_burst_o(max_burst_o),
    .desc_src_o(desc_src_o), .desc_dst_o(desc_dst_o),
    .desc_bytes_o(desc_bytes_o), .desc_cfg_o(desc_cfg_o),
    .dma_done_i(dma_done_i), .dma_active_i(dma_active_i),
    .err_valid_i(err_valid_i), .err_addr_i(err_addr_i),
    .err_src_i(err_src_i), .err_type_i(err_type_i),
    .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (go_o) go_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    int  n;
    bit  aw_done, w_done, aw_go, w_go;
    @(negedge clk);
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < LIM) begin
      aw_go = s_awvalid && s_awready;
      w_go  = s_wvalid && s_wready;
      @(posedge clk);
      @(negedge clk);
      if (aw_go) begin aw_done = 1; s_awvalid = 1'b0; end
      if (w_go) begin w_done = 1; s_wvalid = 1'b0; end
      n++;
    end
    if (n >= LIM) chk("wr_hs_timeout", 32'(n), 0);
    s_bready = 1'b1;
    n = 0;
    while (!s_bvalid && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("wr_b_timeout", 32'(n), 0);
    resp = s_bresp;
    @(posedge clk);
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0;
    n = 0;
    while (!s_arready && n < LIM) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    while (!s_rvalid && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("rd_timeout", 32'(n), 0);
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rr, br;
  logic [7:0]  map_addr [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h20, 8'h24,
                                 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C};

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
    dma_done_i = 0; dma_active_i = 0; err_valid_i = 0; err_addr_i = '0;
    err_src_i = 0; err_type_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_go", go_o, 0);
    chk("rst_irq", irq_o, 0);
    rst = 1'b0;

    foreach (map_addr[i]) begin
      do_read(map_addr[i], rd, rr);
      chk($sformatf("rst_rd_%h", map_addr[i]), rd, 0);
      chk($sformatf("rst_rresp_%h", map_addr[i]), rr, 0);
    end
    do_read(8'h40, rd, rr);
    chk("unmap40_data", rd, 0);
    chk("unmap40_resp", rr, 2);
    do_read(8'h14, rd, rr);
    chk("unmap14_resp", rr, 2);

    // W arrives three cycles ahead of AW, response then stalled
    @(negedge clk);
    s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'b0011; s_wvalid = 1'b1;
    s_bready = 1'b0;
    chk("wfirst_wready", s_wready, 1);
    @(posedge clk);
    @(negedge clk);
    s_wvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wfirst_bvalid_early", s_bvalid, 0);
    s_awaddr = 8'h20; s_awvalid = 1'b1;
    chk("wfirst_awready", s_awready, 1);
    @(posedge clk);
    @(negedge clk);
    s_awvalid = 1'b0;
    chk("wfirst_bvalid", s_bvalid, 1);
    chk("wfirst_src", desc_src_o[31:0], 32'h0000_BEEF);
    repeat (3) @(negedge clk);
    chk("hold_bvalid", s_bvalid, 1);
    chk("hold_bresp", s_bresp, 0);
    s_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_bready = 1'b0;
    chk("bvalid_drop", s_bvalid, 0);

    go_cnt = 0;
    do_write(8'h00, 32'h0000_0409, 4'hF, br);
    repeat (2) @(negedge clk);
    chk("ctrl_resp", br, 0);
    chk("go_pulse", 32'(go_cnt), 1);
    chk("max_burst", max_burst_o, 8'h02);
    chk("abort_low", abort_o, 0);
    do_read(8'h00, rd, rr);
    chk("ctrl_rd", rd, 32'h0000_0408);

    dma_active_i = 1'b1;
    go_cnt = 0;
    do_write(8'h00, 32'h0000_0409, 4'hF, br);
    repeat (2) @(negedge clk);
    chk("go_active_resp", br, 0);
    chk("go_suppressed", 32'(go_cnt), 0);
    do_read(8'h04, rd, rr);
    chk("status_active", rd, 32'h4);
    dma_active_i = 1'b0;

    // two back-to-back errors: the first one is kept
    @(negedge clk);
    err_valid_i = 1; err_addr_i = 32'h1000; err_src_i = 1; err_type_i = 0;
    @(negedge clk);
    chk("irq_lat0", irq_o, 0);
    err_addr_i = 32'h2000; err_src_i = 0; err_type_i = 1;
    @(negedge clk);
    chk("irq_set", irq_o, 1);
    err_valid_i = 0;
    do_read(8'h08, rd, rr);
    chk("err_addr_first", rd, 32'h1000);
    do_read(8'h0C, rd, rr);
    chk("err_info_first", rd, 32'h2);
    do_read(8'h04, rd, rr);
    chk("status_err", rd, 32'h2);
    do_write(8'h04, 32'h2, 4'hF, br);
    chk("w1c_resp", br, 0);
    chk("irq_cleared", irq_o, 0);
    do_read(8'h04, rd, rr);
    chk("status_clr", rd, 0);

    // error strobe on the same edge as the W1C commit
    @(negedge clk);
    s_awaddr = 8'h04; s_awvalid = 1; s_wdata = 32'h2; s_wstrb = 4'hF;
    s_wvalid = 1; s_bready = 1;
    err_valid_i = 1; err_addr_i = 32'h3000; err_src_i = 0; err_type_i = 0;
    chk("coin_ready", s_awready & s_wready, 1);
    @(posedge clk);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0; err_valid_i = 0;
    chk("coin_bvalid", s_bvalid, 1);
    @(posedge clk);
    @(negedge clk);
    s_bready = 0;
    do_read(8'h04, rd, rr);
    chk("coin_err_kept", rd, 32'h2);
    do_read(8'h08, rd, rr);
    chk("coin_err_addr", rd, 32'h3000);
    do_write(8'h04, 32'h3, 4'hF, br);

    @(negedge clk);
    dma_done_i = 1'b1;
    repeat (2) @(negedge clk);
    do_read(8'h04, rd, rr);
    chk("done_set", rd, 32'h1);
    do_write(8'h04, 32'h1, 4'hF, br);
    do_read(8'h04, rd, rr);
    chk("done_edge_only", rd, 0);
    dma_done_i = 1'b0;

    dma_active_i = 1'b1;
    do_write(8'h24, 32'h1234_5678, 4'hF, br);
    chk("desc_busy_resp", br, 2);
    do_read(8'h24, rd, rr);
    chk("desc_busy_keep", rd, 0);
    dma_active_i = 1'b0;
    do_write(8'h08, 32'hFFFF_FFFF, 4'hF, br);
    chk("ro_resp", br, 2);
    do_write(8'h30, 32'hCAFE_F00D, 4'hF, br);
    chk("desc1_resp", br, 0);
    chk("desc1_src", desc_src_o[63:32], 32'hCAFE_F00D);
    do_write(8'h3C, 32'hFF, 4'hF, br);
    chk("desc1_cfg", desc_cfg_o[5:3], 3'h7);
    do_read(8'h3C, rd, rr);
    chk("desc1_cfg_rd", rd, 32'h7);

    // reset lands while the write response is pending
    @(negedge clk);
    s_awaddr = 8'h00; s_awvalid = 1; s_wdata = 32'h2; s_wstrb = 4'hF;
    s_wvalid = 1; s_bready = 0;
    @(posedge clk);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    chk("pre_rst_bvalid", s_bvalid, 1);
    chk("pre_rst_abort", abort_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_bvalid_drop", s_bvalid, 0);
    chk("rst_abort_clr", abort_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_read(8'h00, rd, rr);
    chk("post_rst_ctrl", rd, 0);
    do_read(8'h30, rd, rr);
    chk("post_rst_desc", rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
